muldiv_sequencer: RTL

//  Multi-cycle controller for MULT/MULTU/DIV/DIVU and owner of the HI/LO registers.

---
 rtl/muldiv_if.sv | 17 +
 rtl/muldiv_sequencer.sv | 72 +++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: core-side handshake, HI/LO access and result bus of the multiply/divide sequencer.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             hilo_rd;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, mthi, mtlo, hilo_rd, input busy, done, stall, hi, lo);
    modport slave  (input start, op, a, b, mthi, mtlo, hilo_rd, output busy, done, stall, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial MULT/MULTU/DIV/DIVU on sign magnitudes, owns HI/LO.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   reset_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc, q, m, hi, lo, abs_a, abs_b, rem_s, quo_s;
    logic [WIDTH:0]   div_sh, mul_sum;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic             is_div, neg_q, neg_r, done, busy, signed_op, div_ge;
    always_comb begin
        signed_op = ~bus.op[0];
        abs_a     = (signed_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b     = (signed_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
        div_sh    = {acc, q[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, m};
        mul_sum   = {1'b0, acc} + {1'b0, q[0] ? m : '0};
        prod      = {acc, q};
        prod_s    = neg_q ? -prod : prod;
        rem_s     = neg_r ? -acc : acc;
        quo_s     = neg_q ? -q : q;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    always_comb
        state_nx = (state == IDLE) ? (bus.start ? CALC : IDLE) :
                   (state == CALC) ? ((count == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
    always_comb begin
        busy      = state != IDLE;
        bus.stall = busy & (bus.hilo_rd | bus.start | bus.mthi | bus.mtlo);
    end
    // acc doubles as product high half (MUL) and partial remainder (DIV); q as multiplier / quotient
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {count, acc, q, m, hi, lo, is_div, neg_q, neg_r, done} <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.mthi) hi <= bus.a;
                if (bus.mtlo) lo <= bus.a;
                if (bus.start) begin
                    is_div <= bus.op[1];
                    neg_q  <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_r  <= signed_op & bus.a[WIDTH-1];
                    acc    <= '0;
                    q      <= bus.op[1] ? abs_a : abs_b;
                    m      <= bus.op[1] ? abs_b : abs_a;
                    count  <= '0;
                end
            end else if (state == CALC) begin
                count <= count + 1'b1;
                acc   <= is_div ? (div_ge ? div_sh[WIDTH-1:0] - m : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
                q     <= is_div ? {q[WIDTH-2:0], div_ge} : {mul_sum[0], q[WIDTH-1:1]};
            end else begin
                done <= 1'b1;
                hi   <= is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
                lo   <= is_div ? quo_s : prod_s[WIDTH-1:0];
            end
        end
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule
